// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: FSM encoding, default sizes
// and the counter-width helper.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  localparam int DATA_WIDTH  = 8;
  localparam int VEC_LEN     = 16;
  localparam int MAC_LATENCY = 2;

  // Bits needed to hold values 0..n
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_stream_driver_if.sv
// Operand stream, MAC control and result stream signals of the driver.
// master = driver side, slave = buffers / MAC / downstream side.
interface mac_stream_driver_if #(
  parameter int data_width = 8
) ();

  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [data_width-1:0]     in_a;
  logic [data_width-1:0]     in_b;
  logic                      mac_enable;
  logic                      mac_clear;
  logic [data_width-1:0]     mac_num_1;
  logic [data_width-1:0]     mac_num_2;
  logic [2*data_width:0]     mac_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*data_width:0]     out_data;
  logic                      busy;

  modport master (
    input  start, in_valid, in_a, in_b, mac_result, out_ready,
    output in_ready, mac_enable, mac_clear, mac_num_1, mac_num_2,
           out_valid, out_data, busy
  );

  modport slave (
    output start, in_valid, in_a, in_b, mac_result, out_ready,
    input  in_ready, mac_enable, mac_clear, mac_num_1, mac_num_2,
           out_valid, out_data, busy
  );

endinterface

// File: rtl/nn_up_counter.sv
// Up counter with synchronous clear, increment enable and a terminal-count flag.
module nn_up_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [WIDTH-1:0] count_r;

  // Count register; clear has priority over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc) begin
      count_r <= count_r + WIDTH'(1'b1);
    end
  end

  assign tc = (count_r == WIDTH'(TERMINAL));

endmodule

// File: rtl/mac_stream_driver.sv
// Feeds VEC_LEN operand pairs into the MAC, flushes it and holds the dot product.
// Optional MAC_SKIP_ZERO_EN: pairs with a zero operand are counted but not clocked into the MAC.
module mac_stream_driver
  import nn_pkg::*;
#(
  parameter int data_width  = nn_pkg::DATA_WIDTH,
  parameter int VEC_LEN     = nn_pkg::VEC_LEN,
  parameter int MAC_LATENCY = nn_pkg::MAC_LATENCY
) (
  input logic                 clk,
  input logic                 reset,
  mac_stream_driver_if.master bus
);

  localparam int RES_W = 2 * data_width + 1;
  localparam int ELEM_W  = cnt_width(VEC_LEN);
  localparam int DRAIN_W = cnt_width(MAC_LATENCY);

  state_e                  state_r;
  state_e                  state_s;
  logic                    hs_s;
  logic                    pass_s;
  logic                    elem_tc_s;
  logic                    drain_tc_s;
  logic                    in_ready_s;
  logic                    mac_enable_s;
  logic                    mac_clear_s;
  logic [data_width-1:0]   num_1_s;
  logic [data_width-1:0]   num_2_s;
  logic                    out_valid_s;
  logic                    capture_s;
  logic [RES_W-1:0]        out_data_r;

  assign hs_s = bus.in_valid & (state_r == ST_STREAM);

`ifdef MAC_SKIP_ZERO_EN
  assign pass_s = (bus.in_a != {data_width{1'b0}}) && (bus.in_b != {data_width{1'b0}});
`else
  assign pass_s = 1'b1;
`endif

  nn_up_counter #(.WIDTH(ELEM_W), .TERMINAL(VEC_LEN - 1)) u_elem_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == ST_CLEAR),
    .inc   (hs_s),
    .tc    (elem_tc_s)
  );

  // Drain counter is held at zero outside DRAIN so every flush starts fresh
  nn_up_counter #(.WIDTH(DRAIN_W), .TERMINAL(MAC_LATENCY - 1)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r != ST_DRAIN),
    .inc   (state_r == ST_DRAIN),
    .tc    (drain_tc_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and MAC/handshake control decode
  always_comb begin
    state_s      = state_r;
    in_ready_s   = 1'b0;
    mac_enable_s = 1'b0;
    mac_clear_s  = 1'b0;
    num_1_s      = {data_width{1'b0}};
    num_2_s      = {data_width{1'b0}};
    out_valid_s  = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_s = ST_CLEAR;
        else           state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        mac_clear_s = 1'b1;
        state_s     = ST_STREAM;
      end
      ST_STREAM: begin
        in_ready_s = 1'b1;
        if (hs_s && pass_s) begin
          mac_enable_s = 1'b1;
          num_1_s      = bus.in_a;
          num_2_s      = bus.in_b;
        end else begin
          mac_enable_s = 1'b0;
        end
        if (hs_s && elem_tc_s) state_s = ST_DRAIN;
        else                   state_s = ST_STREAM;
      end
      ST_DRAIN: begin
        // Zero operands push the last real products through the MAC pipeline
        mac_enable_s = 1'b1;
        if (drain_tc_s) state_s = ST_CAPTURE;
        else            state_s = ST_DRAIN;
      end
      ST_CAPTURE: begin
        capture_s = 1'b1;
        state_s   = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid_s = 1'b1;
        if (bus.out_ready) state_s = bus.start ? ST_CLEAR : ST_IDLE;
        else               state_s = ST_HOLD;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Result capture register, stable through HOLD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_r <= {RES_W{1'b0}};
    end else if (capture_s) begin
      out_data_r <= bus.mac_result;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.mac_enable = mac_enable_s;
  assign bus.mac_clear  = mac_clear_s;
  assign bus.mac_num_1  = num_1_s;
  assign bus.mac_num_2  = num_2_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = out_data_r;
  assign bus.busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench for mac_stream_driver with a behavioural MAC (VEC_LEN=4, MAC_LATENCY=2).
module tb_mac_stream_driver;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   en_cnt = 0;

  mac_stream_driver_if #(.data_width(8)) bus ();

  mac_stream_driver #(.data_width(8), .VEC_LEN(4), .MAC_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: LAT-1 product stages feeding a wrapping 17-bit accumulator
  logic [15:0] pipe [0:LAT-2];
  logic [16:0] acc = 17'd0;
  initial for (int i = 0; i < LAT - 1; i++) pipe[i] = 16'd0;

  always @(posedge clk) begin
    if (bus.mac_clear) begin
      acc <= 17'd0;
      for (int i = 0; i < LAT - 1; i++) pipe[i] <= 16'd0;
    end else if (bus.mac_enable) begin
      pipe[0] <= 16'(bus.mac_num_1) * 16'(bus.mac_num_2);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
      acc <= acc + {1'b0, pipe[LAT-2]};
    end
  end
  assign bus.mac_result = acc;

  always @(negedge clk) if (bus.mac_enable === 1'b1) en_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic release_hold(input string tag);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Start a vector (out_ready as set by caller), stream 4 pairs under a valid pattern
  task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [7:0] pat, input int plen, input int start_at,
                         input logic [31:0] exp_out, input int exp_en, input int exp_lat);
    int k;
    int p;
    int rdy;
    int lat;
    int idx;
    int en0;
    k = 0; p = 0; rdy = 0; lat = -1;
    en0 = en_cnt;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_clear"}, {31'd0, bus.mac_clear}, 32'd1);
    chk({tag, "_clear_en"}, {31'd0, bus.mac_enable}, 32'd0);
    for (int i = 1; i < 60 && lat < 0; i++) begin
      idx = (k < 4) ? k : 0;
      bus.start    = (i == start_at);
      bus.in_valid = (k < 4) && (p < 8) && pat[p[2:0]];
      bus.in_a     = av[8*idx +: 8];
      bus.in_b     = bv[8*idx +: 8];
      @(negedge clk);
      if (bus.in_ready) begin
        rdy++;
        if (bus.in_valid) k++;
        p++;
      end
      if (bus.out_valid) lat = i;
      cyc();
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, "_done"}, {31'd0, lat > 0}, 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, {15'd0, bus.out_data}, exp_out);
    chk({tag, "_enables"}, en_cnt - en0, exp_en);
    chk({tag, "_ready_cycles"}, rdy, plen);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_a = 8'd0; bus.in_b = 8'd0;
    bus.out_ready = 1'b0;

    // 1: reset held low with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'($urandom); bus.in_valid = 1'($urandom);
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_ctrl", {27'd0, bus.in_ready, bus.mac_enable, bus.mac_clear, bus.out_valid, bus.busy}, 32'd0);
      chk("rst_nums", {16'd0, bus.mac_num_1, bus.mac_num_2}, 32'd0);
      chk("rst_out_data", {15'd0, bus.out_data}, 32'd0);
      cyc();
    end
    bus.start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'($urandom); bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      cyc();
      chk("idle_stays", {30'd0, bus.busy, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;

    // 2: (1,2),(3,4),(5,6),(7,8) -> 100, latency 9, 6 enables
    run_vec("s2", {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 8'hFF, 4, -1, 32'd100, 6, 9);
    release_hold("s2");

    // 3: full-scale operands wrap: 260100 mod 131072
    run_vec("s3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 4, -1, 32'd129028, 6, 9);
    release_hold("s3");

    // 4: valid pattern 1,0,0,1,0,1,1 -> 7 STREAM cycles
    run_vec("s4", {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 8'h69, 7, -1, 32'd100, 6, -1);
    release_hold("s4");

    // 5: start pulse in DRAIN ignored, HOLD stalled, then back-to-back vector
    run_vec("s5", {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 8'hFF, 4, 6, 32'd100, 6, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s5_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("s5_hold_data", {15'd0, bus.out_data}, 32'd100);
      cyc();
    end
    bus.out_ready = 1'b1;
    run_vec("s5b", 32'h0202_0202, 32'h0202_0202, 8'hFF, 4, -1, 32'd16, 6, 9);
    release_hold("s5b");

    // 6: reset after two pairs, then a clean vector
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd9;
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("s6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("s6_rst_ctrl", {29'd0, bus.in_ready, bus.mac_enable, bus.out_valid}, 32'd0);
    chk("s6_rst_out_data", {15'd0, bus.out_data}, 32'd0);
    bus.in_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    run_vec("s6", 32'h0101_0101, 32'h0101_0101, 8'hFF, 4, -1, 32'd4, 6, 9);
    release_hold("s6");
`ifdef MAC_SKIP_ZERO_EN
    run_vec("s6z", {8'd1, 8'd2, 8'd3, 8'd0}, {8'd1, 8'd5, 8'd0, 8'd9}, 8'hFF, 4, -1, 32'd11, 4, 9);
`else
    run_vec("s6z", {8'd1, 8'd2, 8'd3, 8'd0}, {8'd1, 8'd5, 8'd0, 8'd9}, 8'hFF, 4, -1, 32'd11, 6, 9);
`endif
    release_hold("s6z");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
